// File: rtl/pwm_sync_gen.sv
// rtl/pwm_sync_gen.sv - PWM generator with period-aligned shadow duty update
// Optional macro PWM_INVERT_EN: active-low sout (reset value 1), duty meaning unchanged.
module pwm_sync_gen #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             sout,
    output logic             period_start
);

    localparam int              PW       = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'((2 ** WIDTH) - 2);

`ifdef PWM_INVERT_EN
    localparam logic SOUT_POL = 1'b1;
`else
    localparam logic SOUT_POL = 1'b0;
`endif

    logic [PW-1:0]    pre;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_active;
    logic [WIDTH-1:0] shadow;
    logic             pending;

    logic             tick;
    logic             boundary;
    logic             accept;
    logic [PW-1:0]    pre_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] duty_nxt;

    always_comb begin
        tick     = (pre == PRE_LAST);
        pre_nxt  = tick ? '0 : pre + PW'(1);
        boundary = tick && (cnt == CNT_MAX);
        if (boundary) begin
            cnt_nxt = '0;
        end else if (tick) begin
            cnt_nxt = cnt + WIDTH'(1);
        end else begin
            cnt_nxt = cnt;
        end
        // Shadow only moves into the active duty at a period boundary.
        duty_nxt = (boundary && pending) ? shadow : duty_active;
        accept   = din_valid && !pending;
    end

    assign din_ready = ~pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre          <= '0;
            cnt          <= '0;
            duty_active  <= '0;
            shadow       <= '0;
            pending      <= 1'b0;
            sout         <= SOUT_POL;
            period_start <= 1'b0;
        end else begin
            pre          <= pre_nxt;
            cnt          <= cnt_nxt;
            duty_active  <= duty_nxt;
            period_start <= boundary;
            // accept requires pending==0, so it never collides with the boundary transfer
            if (accept) begin
                shadow  <= din;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            sout <= (cnt_nxt < duty_nxt) ^ SOUT_POL;
        end
    end

endmodule

// File: tb/tb_pwm_sync_gen.sv
// tb/tb_pwm_sync_gen.sv - scoreboard bench for pwm_sync_gen (PRESCALE 1 and 3)
module tb_pwm_sync_gen;

    localparam int PER_T = 255;
`ifdef PWM_INVERT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din = 8'd0;
    logic       rdy0, s0, ps0;
    logic       rdy1, s1, ps1;

    always #5 clk = ~clk;

    pwm_sync_gen #(.WIDTH(8), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .din_ready(rdy0), .sout(s0), .period_start(ps0)
    );

    pwm_sync_gen #(.WIDTH(8), .PRESCALE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .din_ready(rdy1), .sout(s1), .period_start(ps1)
    );

    // Reference model: time since reset release decides period position.
    int pre_of [2] = '{1, 3};
    int duty   [2];
    int shadow [2];
    bit pend   [2];
    int k;

    logic [5:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    function automatic logic [2:0] expect_of(int i);
        int per, pos, c;
        logic s, ps;
        per = PER_T * pre_of[i];
        pos = k % per;
        c   = pos / pre_of[i];
        s   = (c < duty[i]) ^ INV;
        ps  = (pos == 0) && (k != 0);
        return {!pend[i], ps, s};
    endfunction

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < 2; i++) begin
            duty[i] = 0; shadow[i] = 0; pend[i] = 1'b0;
        end
    endtask

    task automatic step(input bit rst, input bit v, input logic [7:0] d);
        @(posedge clk);
        #1;
        if (rst) begin
            rst_n = 1'b0;
            din_valid = 1'b0;
            model_reset();
            exp_q.push_back({expect_of(1), expect_of(0)});
        end else begin
            rst_n = 1'b1;
            din_valid = v;
            din = d;
            exp_q.push_back({expect_of(1), expect_of(0)});
            for (int i = 0; i < 2; i++) begin
                int per;
                bit old;
                per = PER_T * pre_of[i];
                old = pend[i];
                if ((k % per) == per - 1 && old) begin
                    duty[i] = shadow[i];
                    pend[i] = 1'b0;
                end
                if (v && !old) begin
                    shadow[i] = int'(d);
                    pend[i] = 1'b1;
                end
            end
            k++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic wait_cnt(input int c);
        for (int j = 0; j < PER_T && (k % PER_T) != c; j++) step(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [5:0] e;
            e = exp_q.pop_front();
            check("sout_p1",  s0,   e[0]);
            check("pstart_p1", ps0, e[1]);
            check("ready_p1", rdy0, e[2]);
            check("sout_p3",  s1,   e[3]);
            check("pstart_p3", ps1, e[4]);
            check("ready_p3", rdy1, e[5]);
        end
    end

    initial begin
        model_reset();
        repeat (3) step(1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd0);
        run(3 * PER_T);
        step(1'b0, 1'b1, 8'd255);
        run(4 * PER_T);
        step(1'b0, 1'b1, 8'd64);
        run(3 * PER_T + 10);
        wait_cnt(100);
        step(1'b0, 1'b1, 8'd200);
        run(2 * PER_T);
        wait_cnt(50);
        step(1'b0, 1'b1, 8'd200);
        repeat (300) step(1'b0, 1'b1, 8'd10);
        run(600);
        repeat (1500) begin
            int pick;
            logic [7:0] d;
            pick = $urandom_range(0, 4);
            d = (pick == 0) ? 8'd0 : (pick == 1) ? 8'd255 : (pick == 2) ? 8'd1 :
                (pick == 3) ? 8'd254 : 8'($urandom);
            step(1'b0, $urandom_range(0, 7) == 0, d);
        end
        step(1'b0, 1'b1, 8'd128);
        run(800);
        step(1'b0, 1'b1, 8'd128);
        run(800);
        wait_cnt(120);
        repeat (3) step(1'b1, 1'b0, 8'd0);
        run(2 * PER_T + 5);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
